serial_frame_tx: RTL
====================

Name: serial_frame_tx

Overview:
- Downstream neighbour of the 8-bit shift/load register: takes its parallel byte and serialises it onto a single line.
- Frame format: start bit, WIDTH data bits, optional parity bit, stop bit.
- Bit order is selectable per frame. Each bit is held for a programmable number of clock cycles.
- Upstream handshake is valid/ready, so the producing stage stalls while a frame is in flight.

Parameters:
- WIDTH, 8, data bits per frame (>=2).
- CLKS_PER_BIT, 4, clock cycles each line bit is held (>=2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/msb_first hold a byte to send.
- in_ready  output  1  block can accept a byte this cycle.
- in_data  input  WIDTH  parallel byte, e.g. the shift register's out.
- msb_first  input  1  1 = send bit WIDTH-1 first; 0 = send bit 0 first.
- tx  output  1  serial line, registered, idle level 1.
- busy  output  1  a frame is in progress (any state except IDLE).
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (reset).
- Reset values: tx=1, busy=0, done=0, state=IDLE, counters=0. in_ready=1 in the first cycle after reset deasserts.
- in_ready is combinational: (state==IDLE) && !reset.
- Accept: when in_valid && in_ready at a rising edge:
  - in_data and msb_first are captured into a shadow register.
  - Later changes on in_data or msb_first are ignored until the next accept.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - START: tx=0 for CLKS_PER_BIT cycles; it begins in the cycle after the accept edge.
  - DATA: WIDTH bits, each CLKS_PER_BIT cycles.
    - LSB-first: bit index 0..WIDTH-1. MSB-first: WIDTH-1..0.
    - Implemented by shifting the shadow register right (LSB-first) or left (MSB-first) and taking the exiting bit.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then back to IDLE.
- done: asserted for exactly the one cycle in which state returns to IDLE.
  - in_ready is also high in that cycle, so a back-to-back accept is allowed then.
  - Minimum inter-frame line-high time is CLKS_PER_BIT+1 cycles.
- Frame length: (WIDTH+2)*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle, plus CLKS_PER_BIT more if parity is enabled.
- Counters:
  - clk_cnt counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
  - bit_cnt counts 0..WIDTH-1 in DATA; its terminal value advances the state.
  - Widths are $clog2 of the respective ranges, minimum 1.
- in_valid with in_ready low: no effect and no loss. The upstream stage holds in_valid.
- Reset mid-frame: on the next edge state=IDLE and tx=1. The frame is truncated, done is not pulsed, and shadow data is discarded.
- reset together with in_valid: reset wins; nothing is accepted.

Optional Feature:
- Macro: SERIAL_FRAME_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx during PARITY = even parity, i.e. the XOR of all WIDTH data bits captured at accept.
  - Parity is independent of msb_first.
- Not defined: the PARITY state and parity logic are absent; DATA goes directly to STOP.

Decomposition:
- Shared package serial_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - Constants LINE_IDLE=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
- One sub-module, tx_bit_timer:
  - Parameterised by CLKS_PER_BIT, with clk, reset, enable inputs.
  - Outputs bit_tick, high on the last cycle of each bit period.
  - Restarts at 0 when enable rises.

Test Plan:
- Reset: hold reset 3 cycles with in_valid=1 -> tx=1, busy=0, done=0, in_ready=0 during reset; in_ready=1 first cycle after; nothing sent.
- LSB-first (CLKS_PER_BIT=4, parity off): accept in_data=8'h01, msb_first=0 -> tx = 0×4, 1×4, 0×28, 1×4 (40 cycles); done pulses once on cycle 41; busy high cycles 1-40.
- MSB-first: accept in_data=8'h01, msb_first=1 -> tx = 0×4, 0×28, 1×4, 1×4. Changing in_data to 8'hFF mid-frame leaves the waveform unchanged.
- Back-to-back: in_valid held high with 8'h81 then 8'h7E -> second accept in the done cycle; line high exactly 5 cycles between frames; no byte dropped or duplicated.
- Reset mid-frame: assert reset during data bit 3 of 8'hAA -> tx=1 and state IDLE next edge; no done; next frame 8'h55 transmits correctly from its start bit.
- Parity (macro defined): in_data=8'h07 -> parity bit 1; in_data=8'h03 -> parity bit 0. Each held 4 cycles before stop; frame length 44 cycles.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial frame transmitter.
package serial_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: bit_tick marks the last cycle of each CLKS_PER_BIT period.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bit_tick
);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] clk_cnt;

  // Holding the count at zero while disabled restarts the period on enable rise.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      clk_cnt <= '0;
    end else if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + CW'(1);
    end
  end

  assign bit_tick = enable && (clk_cnt == CW'(CLKS_PER_BIT - 1));
endmodule

// File: rtl/serial_frame_tx.sv
// Serialises a parallel byte as start/data/[parity]/stop with valid/ready intake.
// Define SERIAL_FRAME_TX_PARITY_EN to insert an even-parity bit before stop.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             msb_first,
  output logic             tx,
  output logic             busy,
  output logic             done
);
  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shadow;
  logic             msb_r;
  logic             bit_tick;
  logic             accept;
  logic             last_bit;
  logic             shift_en;
  logic             exit_bit;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic             par_r;
`endif

  assign in_ready = (state == IDLE) && !reset;
  assign accept   = in_valid && in_ready;
  assign last_bit = (bit_cnt == BW'(WIDTH - 1));
  assign exit_bit = msb_r ? shadow[WIDTH-1] : shadow[0];
  assign shift_en = bit_tick && ((state == START) || ((state == DATA) && !last_bit));

  tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .enable   (state != IDLE),
    .bit_tick (bit_tick)
  );

  // Shadow holds the frame's data; the bit leaving it is the next line bit.
  always_ff @(posedge clk) begin
    if (accept) begin
      shadow <= in_data;
      msb_r  <= msb_first;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_r  <= ^in_data;
`endif
    end else if (shift_en) begin
      shadow <= msb_r ? (shadow << 1) : (shadow >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= LINE_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= START;
            tx      <= START_LEVEL;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (bit_tick) begin
            state <= DATA;
            tx    <= exit_bit;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (last_bit) begin
              bit_cnt <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
              state   <= PARITY;
              tx      <= par_r;
`else
              state   <= STOP;
              tx      <= STOP_LEVEL;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx      <= exit_bit;
            end
          end
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            state <= STOP;
            tx    <= STOP_LEVEL;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            state <= IDLE;
            tx    <= LINE_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= LINE_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
